// File: rtl/wb_regfile_if.sv
// Writeback-side bundle: the MA/WB triple with its stall qualifier, the two
// decode read ports, and the retirement outputs.
interface wb_regfile_if #(
  parameter int unsigned DW  = 64,
  parameter int unsigned PCW = 64
) ();
  logic           stall;
  logic [PCW-1:0] wb_pc;
  logic [4:0]     wb_rd;
  logic [DW-1:0]  wb_data;
  logic [4:0]     rs1_idx;
  logic [4:0]     rs2_idx;
  logic [DW-1:0]  rs1_data;
  logic [DW-1:0]  rs2_data;
  logic           retire_valid;
  logic [PCW-1:0] retire_pc;
  logic [63:0]    instret;

  modport master (
    output stall, wb_pc, wb_rd, wb_data, rs1_idx, rs2_idx,
    input  rs1_data, rs2_data, retire_valid, retire_pc, instret
  );

  modport slave (
    input  stall, wb_pc, wb_rd, wb_data, rs1_idx, rs2_idx,
    output rs1_data, rs2_data, retire_valid, retire_pc, instret
  );
endinterface

// File: rtl/wb_regfile.sv
// Writeback stage: commits the MA/WB triple into the integer register file,
// serves two bypassed decode read ports and tracks retirement.
module wb_regfile #(
  parameter int unsigned NREG = 32,
  parameter int unsigned DW   = 64,
  parameter int unsigned PCW  = 64
) (
  input logic          clk,
  input logic          rst,
  wb_regfile_if.slave  bus
);

  logic [DW-1:0]  regs_q [NREG];
  logic           retire_valid_q;
  logic [PCW-1:0] retire_pc_q;
  logic [63:0]    instret_q;

  logic commit;
  logic fire;

  assign commit = ~bus.stall & (bus.wb_rd != 5'd0);
  assign fire   = ~bus.stall & (bus.wb_pc != '0);

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs_q[i] <= '0;
      end
    end else if (commit) begin
      regs_q[bus.wb_rd] <= bus.wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_valid_q <= 1'b0;
      retire_pc_q    <= '0;
      instret_q      <= '0;
    end else begin
      retire_valid_q <= fire;
      if (fire) begin
        retire_pc_q <= bus.wb_pc;
        instret_q   <= instret_q + 64'd1;
      end
    end
  end

  // Bypass ignores stall: the held triple is what decode must see.
  always_comb begin
    bus.rs1_data = '0;
    if (bus.rs1_idx != 5'd0) begin
      if (bus.rs1_idx == bus.wb_rd) begin
        bus.rs1_data = bus.wb_data;
      end else begin
        bus.rs1_data = regs_q[bus.rs1_idx];
      end
    end
  end

  always_comb begin
    bus.rs2_data = '0;
    if (bus.rs2_idx != 5'd0) begin
      if (bus.rs2_idx == bus.wb_rd) begin
        bus.rs2_data = bus.wb_data;
      end else begin
        bus.rs2_data = regs_q[bus.rs2_idx];
      end
    end
  end

  assign bus.retire_valid = retire_valid_q;
  assign bus.retire_pc    = retire_pc_q;
  assign bus.instret      = instret_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: retirement scoreboard fed at each edge, register
// model for read-port expectations, one task per scenario.
module tb_wb_regfile;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] cnt;
  } ret_t;

  logic clk;
  logic rst;

  wb_regfile_if #(.DW(64), .PCW(64)) bus ();

  wb_regfile #(.NREG(32), .DW(64), .PCW(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks;
  int n_pass;

  logic [63:0] m_regs [32];
  logic [63:0] m_instret;
  ret_t        sb_q [$];
  logic        mon_fire;
  ret_t        mon_item;

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_instret = '0;
    sb_q.delete();
  endtask

  function automatic logic [63:0] exp_read(input logic [4:0] idx);
    if (idx == 5'd0) return 64'd0;
    if (idx == bus.wb_rd) return bus.wb_data;
    return m_regs[idx];
  endfunction

  // Retirement scoreboard: push at the edge from the inputs, pop when sampled.
  always @(posedge clk) begin
    mon_fire = 1'b0;
    if (rst) begin
      model_reset();
    end else begin
      mon_fire = !bus.stall && (bus.wb_pc != 64'd0);
      if (mon_fire) begin
        m_instret = m_instret + 64'd1;
        sb_q.push_back('{pc: bus.wb_pc, cnt: m_instret});
      end
      if (!bus.stall && bus.wb_rd != 5'd0) m_regs[bus.wb_rd] = bus.wb_data;
    end
    #2;
    if (!rst) begin
      n_checks++;
      if (bus.retire_valid !== mon_fire)
        $display("FAIL retire_valid @%0t: got %b expected %b", $time, bus.retire_valid, mon_fire);
      else n_pass++;
      if (mon_fire) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          $display("FAIL scoreboard_underflow @%0t: got empty queue expected entry", $time);
        end else begin
          mon_item = sb_q.pop_front();
          if (bus.retire_pc !== mon_item.pc || bus.instret !== mon_item.cnt)
            $display("FAIL retire_entry @%0t: got pc=%h cnt=%h expected pc=%h cnt=%h",
                     $time, bus.retire_pc, bus.instret, mon_item.pc, mon_item.cnt);
          else n_pass++;
        end
      end
    end
  end

  task automatic drive(input logic [63:0] pc, input logic [4:0] rd, input logic [63:0] data,
                       input logic st);
    bus.wb_pc   = pc;
    bus.wb_rd   = rd;
    bus.wb_data = data;
    bus.stall   = st;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(64'd0, 5'd0, 64'd0, 1'b0);
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.instret !== 64'd0 || bus.retire_valid !== 1'b0 || bus.retire_pc !== 64'd0)
      $display("FAIL reset_outputs: got instret=%h rv=%b rpc=%h expected 0 0 0",
               bus.instret, bus.retire_valid, bus.retire_pc);
    else n_pass++;
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      bus.rs1_idx = 5'(i);
      bus.rs2_idx = 5'(31 - i);
      #1;
      n_checks++;
      if (bus.rs1_data !== 64'd0 || bus.rs2_data !== 64'd0)
        $display("FAIL reset_read x%0d: got rs1=%h rs2=%h expected 0", i, bus.rs1_data,
                 bus.rs2_data);
      else n_pass++;
    end
    @(negedge clk);
  endtask

  task automatic test_write_bypass();
    drive(64'h8000_0000, 5'd5, 64'hDEAD_BEEF, 1'b0);
    bus.rs1_idx = 5'd5;
    bus.rs2_idx = 5'd6;
    #1;
    n_checks++;
    if (bus.rs1_data !== 64'hDEAD_BEEF || bus.rs2_data !== 64'd0)
      $display("FAIL bypass_x5: got rs1=%h rs2=%h expected deadbeef 0", bus.rs1_data,
               bus.rs2_data);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bus.retire_valid !== 1'b1 || bus.retire_pc !== 64'h8000_0000 || bus.instret !== 64'd1)
      $display("FAIL first_retire: got rv=%b rpc=%h instret=%h expected 1 80000000 1",
               bus.retire_valid, bus.retire_pc, bus.instret);
    else n_pass++;
    drive(64'd0, 5'd0, 64'd0, 1'b0);
    #1;
    n_checks++;
    if (bus.rs1_data !== 64'hDEAD_BEEF)
      $display("FAIL array_x5: got %h expected deadbeef", bus.rs1_data);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_x0();
    drive(64'h8000_0004, 5'd0, 64'h1234, 1'b0);
    bus.rs1_idx = 5'd0;
    bus.rs2_idx = 5'd0;
    #1;
    n_checks++;
    if (bus.rs1_data !== 64'd0 || bus.rs2_data !== 64'd0)
      $display("FAIL x0_read: got rs1=%h rs2=%h expected 0", bus.rs1_data, bus.rs2_data);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bus.instret !== 64'd2 || bus.retire_pc !== 64'h8000_0004)
      $display("FAIL x0_retire: got instret=%h rpc=%h expected 2 80000004", bus.instret,
               bus.retire_pc);
    else n_pass++;
  endtask

  task automatic test_stall();
    logic [63:0] base;
    base = m_instret;
    drive(64'h8000_0008, 5'd7, 64'h55, 1'b1);
    bus.rs1_idx = 5'd7;
    bus.rs2_idx = 5'd7;
    repeat (3) begin
      #1;
      n_checks++;
      if (bus.rs1_data !== 64'h55 || bus.rs2_data !== 64'h55)
        $display("FAIL stall_bypass: got rs1=%h rs2=%h expected 55", bus.rs1_data,
                 bus.rs2_data);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (bus.retire_valid !== 1'b0 || bus.instret !== base)
        $display("FAIL stall_hold: got rv=%b instret=%h expected 0 %h", bus.retire_valid,
                 bus.instret, base);
      else n_pass++;
    end
    bus.stall = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.retire_valid !== 1'b1 || bus.instret !== base + 64'd1)
      $display("FAIL stall_release: got rv=%b instret=%h expected 1 %h", bus.retire_valid,
               bus.instret, base + 64'd1);
    else n_pass++;
    drive(64'd0, 5'd0, 64'd0, 1'b0);
    @(negedge clk);
    n_checks++;
    if (bus.retire_valid !== 1'b0 || bus.instret !== base + 64'd1 || bus.rs1_data !== 64'h55)
      $display("FAIL stall_once: got rv=%b instret=%h x7=%h expected 0 %h 55",
               bus.retire_valid, bus.instret, bus.rs1_data, base + 64'd1);
    else n_pass++;
  endtask

  task automatic test_bubble();
    logic [63:0] base;
    base = m_instret;
    drive(64'd0, 5'd0, 64'd0, 1'b0);
    bus.rs1_idx = 5'd5;
    bus.rs2_idx = 5'd7;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.retire_valid !== 1'b0 || bus.instret !== base || bus.rs1_data !== 64'hDEAD_BEEF
        || bus.rs2_data !== 64'h55)
      $display("FAIL bubble: got rv=%b instret=%h x5=%h x7=%h expected 0 %h deadbeef 55",
               bus.retire_valid, bus.instret, bus.rs1_data, bus.rs2_data, base);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [63:0] e1;
    logic [63:0] e2;
    for (int k = 0; k < 24; k++) begin
      drive(64'h8000_1000 + 64'(k * 4), 5'($urandom_range(0, 31)), {$urandom, $urandom},
            ($urandom_range(0, 3) == 0));
      bus.rs1_idx = 5'($urandom_range(0, 31));
      bus.rs2_idx = (k % 4 == 0) ? bus.rs1_idx : 5'($urandom_range(0, 31));
      if (k % 5 == 0) bus.rs2_idx = bus.wb_rd;
      #1;
      e1 = exp_read(bus.rs1_idx);
      e2 = exp_read(bus.rs2_idx);
      n_checks++;
      if (bus.rs1_data !== e1 || bus.rs2_data !== e2)
        $display("FAIL b2b_read k=%0d: got rs1=%h rs2=%h expected %h %h", k, bus.rs1_data,
                 bus.rs2_data, e1, e2);
      else n_pass++;
      @(negedge clk);
    end
    drive(64'd0, 5'd0, 64'd0, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_wrap();
    drive(64'h8000_0100, 5'd3, 64'hCAFE, 1'b1);
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_q;
    m_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    bus.stall = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.instret !== 64'd0 || bus.retire_valid !== 1'b1)
      $display("FAIL instret_wrap: got instret=%h rv=%b expected 0 1", bus.instret,
               bus.retire_valid);
    else n_pass++;
    drive(64'd0, 5'd0, 64'd0, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    drive(64'h8000_0200, 5'd0, 64'd0, 1'b0);
    bus.rs1_idx = 5'd5;
    bus.rs2_idx = 5'd3;
    @(negedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (bus.retire_valid !== 1'b0 || bus.retire_pc !== 64'd0 || bus.instret !== 64'd0 ||
        bus.rs1_data !== 64'd0 || bus.rs2_data !== 64'd0)
      $display("FAIL async_reset: got rv=%b rpc=%h instret=%h x5=%h x3=%h expected all 0",
               bus.retire_valid, bus.retire_pc, bus.instret, bus.rs1_data, bus.rs2_data);
    else n_pass++;
    drive(64'h8000_0204, 5'd9, 64'h9999, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    drive(64'd0, 5'd0, 64'd0, 1'b0);
    bus.rs1_idx = 5'd9;
    #1;
    n_checks++;
    if (bus.rs1_data !== 64'd0 || bus.instret !== 64'd0 || bus.retire_valid !== 1'b0)
      $display("FAIL reset_discard: got x9=%h instret=%h rv=%b expected 0 0 0",
               bus.rs1_data, bus.instret, bus.retire_valid);
    else n_pass++;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    n_checks = 0;
    n_pass = 0;
    bus.rs1_idx = 5'd0;
    bus.rs2_idx = 5'd0;
    drive(64'd0, 5'd0, 64'd0, 1'b0);
    model_reset();
    test_reset();
    test_write_bypass();
    test_x0();
    test_stall();
    test_bubble();
    test_back_to_back();
    test_wrap();
    test_async_reset();
    n_checks++;
    if (sb_q.size() != 0)
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
